// File: rtl/axonerve_kvs_pkg.sv
// Shared types and widths for the axonerve KVS command arbiter.
// Op codes, FSM states and command/response bundles.
package axonerve_kvs_pkg;

  localparam int OP_W  = 3;
  localparam int KEY_W = 128;
  localparam int MSK_W = 128;
  localparam int PRI_W = 7;
  localparam int VAL_W = 32;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_ERASE  = 3'd1,
    OP_WRITE  = 3'd2,
    OP_READ   = 3'd3,
    OP_SEARCH = 3'd4,
    OP_UPDATE = 3'd5
  } kvs_op_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_DRAINED
  } kvs_state_t;

  typedef struct packed {
    logic update;
    logic search;
    logic read;
    logic write;
    logic erase;
  } kvs_op_oh_t;

  typedef struct packed {
    logic             valid;
    kvs_op_oh_t       op;
    logic [KEY_W-1:0] key;
    logic [MSK_W-1:0] msk;
    logic [PRI_W-1:0] pri;
    logic [VAL_W-1:0] val;
  } kvs_cmd_t;

  typedef struct packed {
    logic             ent_err;
    logic             single_hit;
    logic             multi_hit;
    logic [VAL_W-1:0] val;
  } kvs_rsp_t;

  // Undefined codes map to no op bit; the kernel still acks them.
  function automatic kvs_op_oh_t op_decode(input logic [OP_W-1:0] op);
    kvs_op_oh_t oh;
    oh = '0;
    case (op)
      OP_ERASE:  oh.erase  = 1'b1;
      OP_WRITE:  oh.write  = 1'b1;
      OP_READ:   oh.read   = 1'b1;
      OP_SEARCH: oh.search = 1'b1;
      OP_UPDATE: oh.update = 1'b1;
      default:   oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/axonerve_kvs_tag_fifo.sv
// In-order FIFO of requester IDs for commands awaiting a kernel ACK.
// Register based; DEPTH is a power of two no larger than 16.
module axonerve_kvs_tag_fifo #(
  parameter int ID_W  = 2,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head_id,
  output logic [4:0]      count,
  output logic            empty,
  output logic            full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [ID_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            do_push;
  logic            do_pop;

  assign empty   = (cnt_q == 5'd0);
  assign full    = (cnt_q == 5'(DEPTH));
  assign count   = cnt_q;
  assign head_id = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; push and pop together keep the count.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = push_id;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PW'(1);
    end
    cnt_d = cnt_q + {4'd0, do_push} - {4'd0, do_pop};
  end

  // Storage registers; reset discards every tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axonerve_kvs_arbiter.sv
// Round-robin arbiter sharing one axonerve KVS kernel command port.
// Tags each command with its requester and routes ACKs back in order.
module axonerve_kvs_arbiter
  import axonerve_kvs_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 16,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                     I_CLK,
  input  logic                     I_RST,
  input  logic                     I_DRAIN,
  input  logic [NUM_REQ-1:0]       I_REQ_VALID,
  output logic [NUM_REQ-1:0]       O_REQ_READY,
  input  logic [OP_W*NUM_REQ-1:0]  I_REQ_OP,
  input  logic [KEY_W*NUM_REQ-1:0] I_REQ_KEY_DAT,
  input  logic [MSK_W*NUM_REQ-1:0] I_REQ_EKEY_MSK,
  input  logic [PRI_W*NUM_REQ-1:0] I_REQ_KEY_PRI,
  input  logic [VAL_W*NUM_REQ-1:0] I_REQ_KEY_VALUE,
  output logic [NUM_REQ-1:0]       O_RSP_VALID,
  output logic                     O_RSP_ENT_ERR,
  output logic                     O_RSP_SINGLE_HIT,
  output logic                     O_RSP_MULTI_HIT,
  output logic [VAL_W-1:0]         O_RSP_KEY_VALUE,
  input  logic                     I_KV_READY,
  input  logic                     I_KV_WAIT,
  input  logic                     I_KV_CMD_FULL,
  output logic                     O_KV_CMD_VALID,
  output logic                     O_KV_CMD_ERASE,
  output logic                     O_KV_CMD_WRITE,
  output logic                     O_KV_CMD_READ,
  output logic                     O_KV_CMD_SEARCH,
  output logic                     O_KV_CMD_UPDATE,
  output logic [KEY_W-1:0]         O_KV_KEY_DAT,
  output logic [MSK_W-1:0]         O_KV_EKEY_MSK,
  output logic [PRI_W-1:0]         O_KV_KEY_PRI,
  output logic [VAL_W-1:0]         O_KV_KEY_VALUE,
  input  logic                     I_KV_ACK,
  input  logic                     I_KV_ENT_ERR,
  input  logic                     I_KV_SINGLE_HIT,
  input  logic                     I_KV_MULTI_HIT,
  input  logic [VAL_W-1:0]         I_KV_KEY_VALUE,
  output logic [4:0]               O_OUTSTANDING,
  output logic                     O_IDLE,
  output logic                     O_ORPHAN_ACK
);

  kvs_state_t          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  kvs_cmd_t            cmd_q, cmd_d;
  kvs_rsp_t            rsp_q, rsp_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic                orphan_q, orphan_d;

  logic                grant_en;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gid;
  logic                xfer;
  logic                pop;
  logic [ID_W-1:0]     head_id;
  logic [4:0]          count;
  logic                empty;
  logic                full;

  axonerve_kvs_tag_fifo #(
    .ID_W  (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (I_CLK),
    .rst     (I_RST),
    .push    (xfer),
    .push_id (gid),
    .pop     (pop),
    .head_id (head_id),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  assign grant_en = (state_q == ST_RUN) && I_KV_READY &&
                    !I_KV_WAIT && !I_KV_CMD_FULL && !full;
  assign pop      = I_KV_ACK && !empty;

  // First valid requester at or after the pointer wins the grant.
  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    gid   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (grant_en && !found && I_REQ_VALID[idx]) begin
        gnt[idx] = 1'b1;
        gid      = ID_W'(idx);
        found    = 1'b1;
      end
    end
    xfer = found;
  end

  // Pointer moves past the winner only when a transfer happens.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if (gid == ID_W'(NUM_REQ - 1)) ptr_d = '0;
      else                           ptr_d = gid + ID_W'(1);
    end
  end

  // Register the granted command; fields hold between strobes.
  always_comb begin
    cmd_d       = cmd_q;
    cmd_d.valid = xfer;
    cmd_d.op    = '0;
    if (xfer) begin
      cmd_d.op  = op_decode(I_REQ_OP[gid*OP_W +: OP_W]);
      cmd_d.key = I_REQ_KEY_DAT[gid*KEY_W +: KEY_W];
      cmd_d.msk = I_REQ_EKEY_MSK[gid*MSK_W +: MSK_W];
      cmd_d.pri = I_REQ_KEY_PRI[gid*PRI_W +: PRI_W];
      cmd_d.val = I_REQ_KEY_VALUE[gid*VAL_W +: VAL_W];
    end
  end

  // Route each ACK to the head tag; an ACK with no tag is flagged.
  always_comb begin
    rsp_d       = rsp_q;
    rsp_valid_d = '0;
    orphan_d    = orphan_q;
    if (pop) begin
      rsp_valid_d[head_id] = 1'b1;
      rsp_d.ent_err        = I_KV_ENT_ERR;
      rsp_d.single_hit     = I_KV_SINGLE_HIT;
      rsp_d.multi_hit      = I_KV_MULTI_HIT;
      rsp_d.val            = I_KV_KEY_VALUE;
    end else if (I_KV_ACK) begin
      orphan_d = 1'b1;
    end
  end

  // Run/drain sequencing; losing kernel ready always returns to init.
  always_comb begin
    state_d = state_q;
    if (!I_KV_READY) begin
      state_d = ST_INIT;
    end else begin
      unique case (state_q)
        ST_INIT:    state_d = ST_RUN;
        ST_RUN:     if (I_DRAIN) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (!I_DRAIN)
            state_d = ST_RUN;
          else if (count == 5'd0 && rsp_valid_q == '0)
            state_d = ST_DRAINED;
        end
        ST_DRAINED: if (!I_DRAIN) state_d = ST_RUN;
        default:    state_d = ST_INIT;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      cmd_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= '0;
      orphan_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      orphan_q    <= orphan_d;
    end
  end

  assign O_REQ_READY      = gnt;
  assign O_KV_CMD_VALID   = cmd_q.valid;
  assign O_KV_CMD_ERASE   = cmd_q.op.erase;
  assign O_KV_CMD_WRITE   = cmd_q.op.write;
  assign O_KV_CMD_READ    = cmd_q.op.read;
  assign O_KV_CMD_SEARCH  = cmd_q.op.search;
  assign O_KV_CMD_UPDATE  = cmd_q.op.update;
  assign O_KV_KEY_DAT     = cmd_q.key;
  assign O_KV_EKEY_MSK    = cmd_q.msk;
  assign O_KV_KEY_PRI     = cmd_q.pri;
  assign O_KV_KEY_VALUE   = cmd_q.val;
  assign O_RSP_VALID      = rsp_valid_q;
  assign O_RSP_ENT_ERR    = rsp_q.ent_err;
  assign O_RSP_SINGLE_HIT = rsp_q.single_hit;
  assign O_RSP_MULTI_HIT  = rsp_q.multi_hit;
  assign O_RSP_KEY_VALUE  = rsp_q.val;
  assign O_OUTSTANDING    = count;
  assign O_IDLE           = (state_q == ST_DRAINED);
  assign O_ORPHAN_ACK     = orphan_q;

endmodule

// File: tb/tb_axonerve_kvs_arbiter.sv
// Self-checking bench for axonerve_kvs_arbiter.
// Random stimulus against a queue-based behavioural model.
module tb_axonerve_kvs_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, drain;
  logic [N-1:0]   rv;
  logic [3*N-1:0] rop;
  logic [128*N-1:0] rkey, rmsk;
  logic [7*N-1:0]   rpri;
  logic [32*N-1:0]  rval;
  logic kv_ready, kv_wait, kv_full;
  logic ack, a_err, a_sh, a_mh;
  logic [31:0] a_val;

  logic [N-1:0] rdy, rsp_v;
  logic rsp_err, rsp_sh, rsp_mh;
  logic [31:0] rsp_val;
  logic cmd_v, c_er, c_wr, c_rd, c_se, c_up;
  logic [127:0] c_key, c_msk;
  logic [6:0] c_pri;
  logic [31:0] c_val;
  logic [4:0] outst;
  logic idle, orphan;

  axonerve_kvs_arbiter #(.NUM_REQ(N), .TAG_DEPTH(16)) dut (
    .I_CLK(clk), .I_RST(rst), .I_DRAIN(drain),
    .I_REQ_VALID(rv), .O_REQ_READY(rdy),
    .I_REQ_OP(rop), .I_REQ_KEY_DAT(rkey),
    .I_REQ_EKEY_MSK(rmsk), .I_REQ_KEY_PRI(rpri),
    .I_REQ_KEY_VALUE(rval),
    .O_RSP_VALID(rsp_v), .O_RSP_ENT_ERR(rsp_err),
    .O_RSP_SINGLE_HIT(rsp_sh), .O_RSP_MULTI_HIT(rsp_mh),
    .O_RSP_KEY_VALUE(rsp_val),
    .I_KV_READY(kv_ready), .I_KV_WAIT(kv_wait),
    .I_KV_CMD_FULL(kv_full),
    .O_KV_CMD_VALID(cmd_v), .O_KV_CMD_ERASE(c_er),
    .O_KV_CMD_WRITE(c_wr), .O_KV_CMD_READ(c_rd),
    .O_KV_CMD_SEARCH(c_se), .O_KV_CMD_UPDATE(c_up),
    .O_KV_KEY_DAT(c_key), .O_KV_EKEY_MSK(c_msk),
    .O_KV_KEY_PRI(c_pri), .O_KV_KEY_VALUE(c_val),
    .I_KV_ACK(ack), .I_KV_ENT_ERR(a_err),
    .I_KV_SINGLE_HIT(a_sh), .I_KV_MULTI_HIT(a_mh),
    .I_KV_KEY_VALUE(a_val),
    .O_OUTSTANDING(outst), .O_IDLE(idle),
    .O_ORPHAN_ACK(orphan)
  );

  int total = 0;
  int bad = 0;

  // model: 0 init, 1 run, 2 drain, 3 drained
  int q[$];
  int rr;
  int mst;
  bit m_orphan;
  logic [N-1:0] prev_rsp;

  function automatic logic [4:0] oh(input logic [2:0] op);
    if (op >= 3'd1 && op <= 3'd5) return 5'd1 << (op - 3'd1);
    return 5'd0;
  endfunction

  task automatic model_reset();
    q.delete();
    rr = 0;
    mst = 0;
    m_orphan = 0;
    prev_rsp = '0;
  endtask

  task automatic rand_req(input int i, input logic [2:0] op);
    rop[i*3 +: 3]     = op;
    rkey[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    rmsk[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    rpri[i*7 +: 7]    = 7'($urandom);
    rval[i*32 +: 32]  = $urandom;
  endtask

  task automatic rand_ack_data();
    a_err = 1'($urandom);
    a_sh  = 1'($urandom);
    a_mh  = 1'($urandom);
    a_val = $urandom;
  endtask

  task automatic step();
    int g, cnt;
    bit en, e_cv;
    logic [N-1:0] eg, e_rsp;
    logic [4:0] e_op;
    logic [127:0] e_key, e_msk;
    logic [6:0] e_pri;
    logic [31:0] e_val, e_rval;
    logic e_err, e_sh, e_mh;
    e_op = '0; e_key = '0; e_msk = '0; e_pri = '0;
    e_val = '0; e_rval = '0; e_err = 0; e_sh = 0; e_mh = 0;
    #1;
    cnt = q.size();
    en = (mst == 1) && kv_ready && !kv_wait && !kv_full && cnt < 16;
    eg = '0;
    g = -1;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (rr + k) % N;
        if (g < 0 && rv[i]) begin
          g = i;
          eg[i] = 1'b1;
        end
      end
    end
    total++;
    if (rdy !== eg)
      $display("FAIL grant: got %b want %b", rdy, eg);
    if (rdy !== eg) bad++;
    total++;
    if (outst !== 5'(cnt)) begin
      bad++;
      $display("FAIL outstanding: got %0d want %0d", outst, cnt);
    end
    total++;
    if (idle !== (mst == 3)) begin
      bad++;
      $display("FAIL idle: got %b want %b", idle, mst == 3);
    end
    e_cv = (g >= 0);
    if (g >= 0) begin
      e_op  = oh(rop[g*3 +: 3]);
      e_key = rkey[g*128 +: 128];
      e_msk = rmsk[g*128 +: 128];
      e_pri = rpri[g*7 +: 7];
      e_val = rval[g*32 +: 32];
      q.push_back(g);
      rr = (g + 1) % N;
    end
    e_rsp = '0;
    if (ack) begin
      if (cnt > 0) begin
        int h;
        h = q.pop_front();
        e_rsp[h] = 1'b1;
        e_err = a_err; e_sh = a_sh; e_mh = a_mh;
        e_rval = a_val;
      end else begin
        m_orphan = 1;
      end
    end
    if (!kv_ready) mst = 0;
    else case (mst)
      0: mst = 1;
      1: if (drain) mst = 2;
      2: if (!drain) mst = 1;
         else if (cnt == 0 && prev_rsp == '0) mst = 3;
      default: if (!drain) mst = 1;
    endcase
    prev_rsp = e_rsp;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (cmd_v !== e_cv) begin
      bad++;
      $display("FAIL cmd_valid: got %b want %b", cmd_v, e_cv);
    end
    if (e_cv) begin
      total++;
      if ({c_up, c_se, c_rd, c_wr, c_er, c_key, c_msk, c_pri, c_val}
          !== {e_op, e_key, e_msk, e_pri, e_val}) begin
        bad++;
        $display("FAIL cmd_fields: got op %b val %h want op %b val %h",
                 {c_up, c_se, c_rd, c_wr, c_er}, c_val, e_op, e_val);
      end
    end
    total++;
    if (rsp_v !== e_rsp) begin
      bad++;
      $display("FAIL rsp_valid: got %b want %b", rsp_v, e_rsp);
    end
    if (e_rsp != '0) begin
      total++;
      if ({rsp_err, rsp_sh, rsp_mh, rsp_val}
          !== {e_err, e_sh, e_mh, e_rval}) begin
        bad++;
        $display("FAIL rsp_data: got %b%b%b %h want %b%b%b %h",
                 rsp_err, rsp_sh, rsp_mh, rsp_val,
                 e_err, e_sh, e_mh, e_rval);
      end
    end
    total++;
    if (orphan !== m_orphan) begin
      bad++;
      $display("FAIL orphan: got %b want %b", orphan, m_orphan);
    end
  endtask

  task automatic flush();
    rv = '0;
    ack = 1'b1;
    while (q.size() > 0) begin
      rand_ack_data();
      step();
    end
    ack = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drain = 0; rv = '1; rop = '0; rkey = '0; rmsk = '0;
    rpri = '0; rval = '0; kv_ready = 1; kv_wait = 0;
    kv_full = 0; ack = 0; a_err = 0; a_sh = 0; a_mh = 0;
    a_val = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (rdy !== '0) begin
      bad++;
      $display("FAIL rst_ready: got %b want 0", rdy);
    end
    total++;
    if ({cmd_v, c_key, c_val} !== '0) begin
      bad++;
      $display("FAIL rst_cmd: got %b want 0", cmd_v);
    end
    total++;
    if ({rsp_v, rsp_val, outst, idle, orphan} !== '0) begin
      bad++;
      $display("FAIL rst_status: got %b %0d %b %b want 0",
               rsp_v, outst, idle, orphan);
    end
    @(negedge clk);
    rst = 1'b0;
    rv = '0;
    model_reset();
    step();
  endtask

  task automatic test_single();
    rand_req(0, 3'd4);
    rkey[127:0] = 128'h1234;
    rv = 4'b0001;
    step();
    rv = '0;
    ack = 1; a_err = 0; a_sh = 1; a_mh = 0; a_val = 32'hCAFE;
    step();
    ack = 0;
    total++;
    if (rsp_v !== 4'b0001 || rsp_val !== 32'hCAFE) begin
      bad++;
      $display("FAIL single_rsp: got %b %h want 0001 cafe",
               rsp_v, rsp_val);
    end
    step();
  endtask

  task automatic test_round_robin();
    rv = '1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) rand_req(i, 3'($urandom));
      step();
    end
    rv = '0;
    total++;
    if (outst !== 5'd8) begin
      bad++;
      $display("FAIL rr_outstanding: got %0d want 8", outst);
    end
    flush();
  endtask

  task automatic test_tag_full();
    rv = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      rand_req(1, 3'($urandom));
      step();
    end
    total++;
    if (outst !== 5'd16) begin
      bad++;
      $display("FAIL full_outstanding: got %0d want 16", outst);
    end
    ack = 1;
    rand_ack_data();
    step();
    ack = 0;
    step();
    step();
    flush();
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 40; c++) begin
      rv = 4'($urandom);
      for (int i = 0; i < N; i++) rand_req(i, 3'($urandom));
      kv_full = ($urandom_range(0, 2) == 0);
      kv_wait = ($urandom_range(0, 2) == 0);
      ack = (q.size() > 0) && ($urandom_range(0, 1) == 0);
      rand_ack_data();
      step();
    end
    kv_full = 0;
    kv_wait = 0;
    flush();
  endtask

  task automatic test_drain();
    rv = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) rand_req(i, 3'($urandom));
      step();
    end
    rv = '0;
    drain = 1;
    step();
    rv = '1;
    ack = 1;
    for (int c = 0; c < 3; c++) begin
      rand_ack_data();
      step();
    end
    ack = 0;
    for (int c = 0; c < 8 && mst != 3; c++) step();
    total++;
    if (idle !== 1'b1) begin
      bad++;
      $display("FAIL drained_idle: got %b want 1", idle);
    end
    drain = 0;
    step();
    step();
    step();
    flush();
  endtask

  task automatic test_orphan();
    rv = '0;
    ack = 1;
    rand_ack_data();
    step();
    ack = 0;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rv = 4'($urandom);
      for (int i = 0; i < N; i++) rand_req(i, 3'($urandom));
      kv_full  = ($urandom_range(0, 3) == 0);
      kv_wait  = ($urandom_range(0, 3) == 0);
      kv_ready = ($urandom_range(0, 40) != 0);
      if ($urandom_range(0, 15) == 0) drain = ~drain;
      ack = (q.size() > 0) && ($urandom_range(0, 1) == 0);
      rand_ack_data();
      step();
    end
    kv_full = 0; kv_wait = 0; kv_ready = 1; drain = 0;
    flush();
  endtask

  task automatic test_reset_mid();
    rv = '1;
    for (int c = 0; c < 3; c++) step();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (rdy !== '0 || cmd_v !== 1'b0 || rsp_v !== '0) begin
      bad++;
      $display("FAIL midrst_out: got %b %b %b want 0",
               rdy, cmd_v, rsp_v);
    end
    total++;
    if (outst !== 5'd0 || orphan !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state: got %0d %b want 0 0",
               outst, orphan);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rv = '0;
    step();
    rv = '1;
    for (int i = 0; i < N; i++) rand_req(i, 3'd2);
    step();
    step();
    flush();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_tag_full();
    test_backpressure();
    test_drain();
    test_orphan();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
